hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller: the producer side of the execute stage's `stall_flag` input and the consumer of its `branch_out` output. Each cycle it detects load-use hazards between decode and execute, and turns a taken branch reported by execute into PC redirect and front-end flush controls. It drives the PC register, IF/ID and ID/EX write enables and flushes, and keeps saturating stall and flush event counters. Forwarding stays inside the execute stage; this block handles only the hazards forwarding cannot cover.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard/flush control slice.
// State encodings, register-zero constant and the IF/ID flush NOP.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Asynchronous active-high reset clears it to zero.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the pipeline.
// Controls are combinational; state, flush timer and target are registered.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_addr,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             stall_flag,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      st, st_nx;
  logic [2:0]  fc, fc_nx;
  logic [31:0] tgt_q;
  logic        lu;
  logic        stall_inc;

  assign lu = ex_mem_read
            && (ex_rt_addr != REG_ZERO)
            && ((ex_rt_addr == id_rs_addr)
             || (id_uses_rt && (ex_rt_addr == id_rt_addr)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= RUN;
      fc    <= '0;
      tgt_q <= '0;
    end else begin
      st <= st_nx;
      fc <= fc_nx;
      if (branch_taken) tgt_q <= branch_target;
    end
  end

  always_comb begin
    st_nx       = st;
    fc_nx       = fc;
    stall_flag  = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_sel      = 1'b0;
    unique case (st)
      RUN: begin
        if (branch_taken) begin
          st_nx       = FLUSH;
          fc_nx       = FC_LOAD;
          pc_sel      = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          st_nx       = STALL;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_flag  = 1'b1;
        end
      end
      STALL: begin
        if (branch_taken) begin
          st_nx = FLUSH;
          fc_nx = FC_LOAD;
        end else begin
          st_nx = RUN;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        // a fresh redirect restarts the flush window
        if (branch_taken) begin
          fc_nx = FC_LOAD;
        end else if (fc == 3'd0) begin
          st_nx = RUN;
        end else begin
          fc_nx = fc - 3'd1;
        end
      end
      default: begin
        st_nx = RUN;
        fc_nx = '0;
      end
    endcase
  end

  assign pc_target = branch_taken ? branch_target : tgt_q;
  assign state     = st;
  assign stall_inc = (st == RUN) && lu && !branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=2 and 3-bit counters.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rt_addr;
  logic        id_uses_rt, ex_mem_read, branch_taken;
  logic [31:0] branch_target;
  logic        stall_flag, pc_write, if_id_write;
  logic        if_id_flush, id_ex_flush, pc_sel;
  logic [31:0] pc_target;
  logic [2:0]  stall_count, flush_count;
  logic [1:0]  state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rt_addr    (ex_rt_addr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall_flag    (stall_flag),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .pc_sel        (pc_sel),
    .pc_target     (pc_target),
    .stall_count   (stall_count),
    .flush_count   (flush_count),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs_addr    = 5'd0;
    id_rt_addr    = 5'd0;
    id_uses_rt    = 1'b0;
    ex_mem_read   = 1'b0;
    ex_rt_addr    = 5'd0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  task automatic load_use();
    ex_mem_read = 1'b1;
    ex_rt_addr  = 5'd5;
    id_rs_addr  = 5'd5;
    tick();
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    chk("rst_state", 32'(state), 32'(RUN));
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_if_id_write", 32'(if_id_write), 32'd1);
    chk("rst_if_id_flush", 32'(if_id_flush), 32'd0);
    chk("rst_id_ex_flush", 32'(id_ex_flush), 32'd0);
    chk("rst_stall_flag", 32'(stall_flag), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_pc_target", pc_target, 32'h0);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // load-use on rs
    ex_mem_read = 1'b1;
    ex_rt_addr  = 5'd5;
    id_rs_addr  = 5'd5;
    #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_stall_flag", 32'(stall_flag), 32'd1);
    tick();
    idle();
    #1;
    chk("lu_state_stall", 32'(state), 32'(STALL));
    chk("lu_nx_pc_write", 32'(pc_write), 32'd1);
    chk("lu_nx_if_id_write", 32'(if_id_write), 32'd1);
    chk("lu_nx_id_ex_flush", 32'(id_ex_flush), 32'd0);
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    tick();
    chk("lu_back_run", 32'(state), 32'(RUN));

    // no false stall: r0, and rt not used
    ex_mem_read = 1'b1;
    ex_rt_addr  = 5'd0;
    id_rs_addr  = 5'd0;
    #1;
    chk("r0_no_stall", 32'(stall_flag), 32'd0);
    ex_rt_addr = 5'd7;
    id_rt_addr = 5'd7;
    id_rs_addr = 5'd3;
    #1;
    chk("rt_unused_no_stall", 32'(stall_flag), 32'd0);
    chk("rt_unused_pc_write", 32'(pc_write), 32'd1);
    tick();
    chk("nostall_state", 32'(state), 32'(RUN));
    chk("nostall_cnt", 32'(stall_count), 32'd1);
    id_uses_rt = 1'b1;
    #1;
    chk("rt_used_stall", 32'(stall_flag), 32'd1);
    tick();
    idle();
    chk("rt_used_state", 32'(state), 32'(STALL));
    chk("rt_used_cnt", 32'(stall_count), 32'd2);
    tick();

    // taken branch
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #1;
    chk("br_pc_sel", 32'(pc_sel), 32'd1);
    chk("br_pc_target", pc_target, 32'h40);
    chk("br_flush1", 32'(if_id_flush), 32'd1);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    tick();
    idle();
    branch_target = 32'h99;
    #1;
    chk("br_state_f1", 32'(state), 32'(FLUSH));
    chk("br_flush2", 32'(if_id_flush), 32'd1);
    chk("br_f1_pc_sel", 32'(pc_sel), 32'd0);
    chk("br_target_held", pc_target, 32'h40);
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    tick();
    chk("br_flush3", 32'(if_id_flush), 32'd1);
    chk("br_idex3", 32'(id_ex_flush), 32'd1);
    tick();
    chk("br_end_state", 32'(state), 32'(RUN));
    chk("br_end_flush", 32'(if_id_flush), 32'd0);

    // branch and load-use together
    branch_taken  = 1'b1;
    branch_target = 32'h50;
    ex_mem_read   = 1'b1;
    ex_rt_addr    = 5'd5;
    id_rs_addr    = 5'd5;
    #1;
    chk("sim_pc_write", 32'(pc_write), 32'd1);
    chk("sim_pc_sel", 32'(pc_sel), 32'd1);
    chk("sim_stall_flag", 32'(stall_flag), 32'd0);
    tick();
    idle();
    chk("sim_state", 32'(state), 32'(FLUSH));
    chk("sim_stall_cnt", 32'(stall_count), 32'd2);
    chk("sim_flush_cnt", 32'(flush_count), 32'd2);
    tick();

    // second branch in the 2nd FLUSH cycle
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    #1;
    chk("b2b_state", 32'(state), 32'(FLUSH));
    chk("b2b_target", pc_target, 32'h80);
    tick();
    idle();
    chk("b2b_ext1", 32'(state), 32'(FLUSH));
    chk("b2b_ext1_flush", 32'(if_id_flush), 32'd1);
    chk("b2b_target_held", pc_target, 32'h80);
    chk("b2b_flush_cnt", 32'(flush_count), 32'd3);
    tick();
    chk("b2b_ext2", 32'(state), 32'(FLUSH));
    tick();
    chk("b2b_done", 32'(state), 32'(RUN));

    // saturation
    for (int i = 0; i < 9; i++) load_use();
    chk("sat_stall_cnt", 32'(stall_count), 32'd7);

    // reset mid-FLUSH
    branch_taken  = 1'b1;
    branch_target = 32'h60;
    tick();
    idle();
    chk("pre_rst_state", 32'(state), 32'(FLUSH));
    chk("pre_rst_fcnt", 32'(flush_count), 32'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 32'(RUN));
    chk("mid_rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("mid_rst_flush_cnt", 32'(flush_count), 32'd0);
    chk("mid_rst_target", pc_target, 32'h0);
    chk("mid_rst_flush", 32'(if_id_flush), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 32'(RUN));
    chk("post_rst_flush", 32'(id_ex_flush), 32'd0);
    chk("post_rst_pc_sel", 32'(pc_sel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
